// File: rtl/fir_pkg.sv
// Shared definitions for the ROM-fed FIR datapath: sequencer states and the
// default geometry constants used by the sequencer and the FIR top level.
package fir_pkg;

   localparam int FIR_DEF_ADDR_W    = 9;
   localparam int FIR_DEF_ROM_LAT   = 1;
   localparam int FIR_DEF_FIR_LAT   = 2;
   localparam int FIR_DEF_FLUSH_CYC = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FLUSH = 2'd1,
      ST_RUN   = 2'd2,
      ST_DRAIN = 2'd3
   } fir_state_e;

endpackage

// File: rtl/fir_seq_ctrl_if.sv
// Host/datapath bundle of the FIR sequencer: run request side (master drives)
// and ROM address / FIR control / status side (slave drives).
interface fir_seq_ctrl_if
   import fir_pkg::*;
#(
   parameter int ADDR_W = FIR_DEF_ADDR_W
);
   logic              start;
   logic              abort;
   logic              loop;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W:0]   len;
   logic [ADDR_W-1:0] address;
   logic              fir_clr_n;
   logic              sample_valid;
   logic [ADDR_W-1:0] sample_idx;
   logic              busy;
   logic              done;

   modport master (
      output start, abort, loop, base_addr, len,
      input  address, fir_clr_n, sample_valid, sample_idx, busy, done
   );

   modport slave (
      input  start, abort, loop, base_addr, len,
      output address, fir_clr_n, sample_valid, sample_idx, busy, done
   );
endinterface

// File: rtl/fir_valid_pipe.sv
// Valid-bit delay line matching the ROM+FIR latency, with synchronous clear.
// pending flags any valid still travelling ahead of the output stage.
module fir_valid_pipe #(
   parameter int DEPTH = 3
) (
   input  logic clk,
   input  logic rest,
   input  logic clr,
   input  logic din,
   output logic dout,
   output logic dout_nxt,
   output logic pending
);
   logic [DEPTH-1:0] stage_q;
   logic [DEPTH-1:0] stage_d;

   always_comb begin
      stage_d    = '0;
      stage_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
         stage_d[i] = stage_q[i-1];
      end
      if (clr) begin
         stage_d = '0;
      end
   end

   always_comb begin
      pending = 1'b0;
      for (int i = 0; i < DEPTH - 1; i++) begin
         pending = pending | stage_q[i];
      end
   end

   always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign dout     = stage_q[DEPTH-1];
   assign dout_nxt = stage_d[DEPTH-1];
endmodule

// File: rtl/fir_seq_ctrl.sv
// FIR window sequencer: flushes the FIR, streams ROM addresses for one window
// and flags aligned FIR results. Window looping is built with FIR_SEQ_LOOP_EN.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for start; address parked at latched base
// ST_FLUSH | FIR delay line held in clear for FLUSH_CYC cycles
// ST_RUN   | one ROM address per cycle, len addresses per window
// ST_DRAIN | address held until the last valid leaves the pipeline
module fir_seq_ctrl
   import fir_pkg::*;
#(
   parameter int ADDR_W    = FIR_DEF_ADDR_W,
   parameter int ROM_LAT   = FIR_DEF_ROM_LAT,
   parameter int FIR_LAT   = FIR_DEF_FIR_LAT,
   parameter int FLUSH_CYC = FIR_DEF_FLUSH_CYC
) (
   input  logic           clk,
   input  logic           rest,
   fir_seq_ctrl_if.slave  bus
);
   localparam int PIPE_D = ROM_LAT + FIR_LAT;
   localparam int LEN_W  = ADDR_W + 1;
   localparam int CNT_W  = (LEN_W > $clog2(FLUSH_CYC)) ? LEN_W : $clog2(FLUSH_CYC);

   fir_state_e        state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] address_q, address_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              fir_clr_n_q, fir_clr_n_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [CNT_W-1:0]  win_top;
   logic              abort_hit;
   logic              loop_again;
   logic              vld_out, vld_nxt, vld_pending;

`ifdef FIR_SEQ_LOOP_EN
   assign loop_again = bus.loop;
`else
   assign loop_again = 1'b0;
`endif

   // len of zero encodes a full 2^ADDR_W window
   assign win_top   = (len_q == '0) ? CNT_W'((1 << ADDR_W) - 1) : CNT_W'(len_q - 1'b1);
   assign abort_hit = bus.abort && (state_q != ST_IDLE);

   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      address_d = address_q;

      case (state_q)
         ST_IDLE: begin
            address_d = base_q;
            if (bus.start && !bus.abort) begin
               state_d   = ST_FLUSH;
               base_d    = bus.base_addr;
               len_d     = bus.len;
               cnt_d     = CNT_W'(FLUSH_CYC - 1);
               address_d = bus.base_addr;
            end
         end
         ST_FLUSH: begin
            if (cnt_q == '0) begin
               state_d = ST_RUN;
               cnt_d   = win_top;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_RUN: begin
            if (cnt_q == '0) begin
               if (loop_again) begin
                  cnt_d     = win_top;
                  address_d = base_q;
               end else begin
                  state_d = ST_DRAIN;
               end
            end else begin
               cnt_d     = cnt_q - 1'b1;
               address_d = address_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            if (!vld_pending) begin
               state_d   = ST_IDLE;
               address_d = base_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (abort_hit) begin
         state_d   = ST_IDLE;
         cnt_d     = '0;
         address_d = base_q;
      end
   end

   always_comb begin
      busy_d      = (state_d != ST_IDLE);
      done_d      = (state_q == ST_DRAIN) && (state_d == ST_IDLE) && !abort_hit;
      fir_clr_n_d = !((state_d == ST_FLUSH) || abort_hit);
      idx_d       = idx_q;
      if (abort_hit) begin
         idx_d = '0;
      end else if (vld_nxt) begin
         // restart at each window seam so looped windows index from 0 again
         idx_d = (vld_out && (idx_q != win_top[ADDR_W-1:0])) ? idx_q + 1'b1 : '0;
      end
   end

   fir_valid_pipe #(
      .DEPTH (PIPE_D)
   ) u_valid_pipe (
      .clk      (clk),
      .rest     (rest),
      .clr      (abort_hit),
      .din      (state_q == ST_RUN),
      .dout     (vld_out),
      .dout_nxt (vld_nxt),
      .pending  (vld_pending)
   );

   always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
         state_q     <= ST_IDLE;
         base_q      <= '0;
         len_q       <= '0;
         cnt_q       <= '0;
         address_q   <= '0;
         idx_q       <= '0;
         fir_clr_n_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         address_q   <= address_d;
         idx_q       <= idx_d;
         fir_clr_n_q <= fir_clr_n_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign bus.address      = address_q;
   assign bus.fir_clr_n    = fir_clr_n_q;
   assign bus.sample_valid = vld_out;
   assign bus.sample_idx   = idx_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
endmodule
